// File: rtl/rom_axi_rd_slave_if.sv
//------------------------------------------------------------------------------
// Module     : rom_axi_rd_slave_if
// Description: AXI4 read-address / read-data channel bundle between an AXI
//              master (the interconnect) and the rom_axi_rd_slave bridge.
//              Signals: ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
//              ARVALID_S, ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S,
//              RVALID_S, RREADY_S.
//              Modports: master (drives AR channel and RREADY_S),
//                        slave  (drives ARREADY_S and the R channel).
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

interface rom_axi_rd_slave_if #(
    parameter int ID_W = `AXI_IDS_BITS
);
    logic [ID_W-1:0]            ARID_S;
    logic [`AXI_ADDR_BITS-1:0]  ARADDR_S;
    logic [`AXI_LEN_BITS-1:0]   ARLEN_S;
    logic [`AXI_SIZE_BITS-1:0]  ARSIZE_S;
    logic [1:0]                 ARBURST_S;
    logic                       ARVALID_S;
    logic                       ARREADY_S;
    logic [ID_W-1:0]            RID_S;
    logic [31:0]                RDATA_S;
    logic [1:0]                 RRESP_S;
    logic                       RLAST_S;
    logic                       RVALID_S;
    logic                       RREADY_S;

    modport master (
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
        input  ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
    );

    modport slave (
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
        output ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
    );
endinterface

`default_nettype wire

// File: rtl/rom_axi_rd_slave.sv
//------------------------------------------------------------------------------
// Module     : rom_axi_rd_slave
// Description: AXI4 read-only slave bridging the interconnect slave port to a
//              synchronous boot ROM. Supports FIXED/INCR (and, when the macro
//              ROM_WRAP_EN is defined, WRAP) bursts of up to 16 beats, a
//              configurable ROM access latency, per-beat SLVERR/DECERR and
//              full RREADY back-pressure. One transaction at a time.
// Ports      : ACLK        - clock
//              ARESETn     - asynchronous active-low reset
//              axi         - AR/R channels (rom_axi_rd_slave_if.slave)
//              ROM_enable  - ROM chip enable
//              ROM_read    - ROM read strobe
//              ROM_address - ROM word address
//              ROM_out     - ROM read data
// Config     : `ROM_WRAP_EN - enables WRAP bursts with LEN in {1,3,7,15};
//              when undefined every WRAP burst returns SLVERR.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module rom_axi_rd_slave #(
    parameter int ADDR_W  = 12,
    parameter int ROM_LAT = 1,
    parameter int ID_W    = `AXI_IDS_BITS
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    rom_axi_rd_slave_if.slave  axi,
    output logic               ROM_enable,
    output logic               ROM_read,
    output logic [ADDR_W-1:0]  ROM_address,
    input  logic [31:0]        ROM_out
);

    localparam int c_LEN_W = `AXI_LEN_BITS;
    localparam int c_LAT_W = $clog2(ROM_LAT + 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_DATA   = 2'd2;
    localparam logic [1:0] c_ERR    = 2'd3;

    localparam logic [1:0] c_FIXED  = 2'd0;
    localparam logic [1:0] c_INCR   = 2'd1;
    localparam logic [1:0] c_WRAP   = 2'd2;

    logic [1:0]          r_state;
    logic [ID_W-1:0]     r_rid;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_LEN_W-1:0]  r_len;
    logic [1:0]          r_burst;
    logic [c_LEN_W-1:0]  r_beat;
    logic [c_LAT_W-1:0]  r_lat;
    logic                r_arready;
    logic                r_rvalid;
    logic                r_rlast;
    logic [31:0]         r_rdata;
    logic [1:0]          r_rresp;
    logic                r_rom_en;
    logic [ADDR_W-1:0]   r_rom_addr;

    logic [ADDR_W-1:0]   w_ar_word;
    logic                w_wrap_ok;
    logic                w_slverr;
    logic                w_decerr;
    logic [ADDR_W-1:0]   w_next_addr;
    logic                w_unused;

    assign w_ar_word = axi.ARADDR_S[ADDR_W+1:2];
    assign w_unused  = ^axi.ARADDR_S[1:0];

`ifdef ROM_WRAP_EN
    // Only power-of-two burst lengths keep the wrap boundary aligned.
    assign w_wrap_ok = (axi.ARLEN_S == c_LEN_W'(1)) || (axi.ARLEN_S == c_LEN_W'(3)) ||
                       (axi.ARLEN_S == c_LEN_W'(7)) || (axi.ARLEN_S == c_LEN_W'(15));
`else
    assign w_wrap_ok = 1'b0;
`endif

    assign w_slverr = (axi.ARSIZE_S != `AXI_SIZE_BITS'(2)) || (axi.ARBURST_S == 2'd3) ||
                      ((axi.ARBURST_S == c_WRAP) && !w_wrap_ok);
    assign w_decerr = |axi.ARADDR_S[`AXI_ADDR_BITS-1:ADDR_W+2];

    always_comb begin
        w_next_addr = r_addr;
        case (r_burst)
            c_FIXED: w_next_addr = r_addr;
            c_INCR:  w_next_addr = r_addr + ADDR_W'(1);
`ifdef ROM_WRAP_EN
            // LEN is 2^k-1, so it doubles as the mask of the wrapping bits.
            c_WRAP:  w_next_addr = (r_addr & ~ADDR_W'(r_len)) |
                                   ((r_addr + ADDR_W'(1)) & ADDR_W'(r_len));
`endif
            default: w_next_addr = r_addr;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state    <= c_IDLE;
            r_rid      <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_burst    <= '0;
            r_beat     <= '0;
            r_lat      <= '0;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= '0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_arready <= 1'b1;
                    if (axi.ARVALID_S && r_arready) begin
                        r_arready <= 1'b0;
                        r_rid     <= axi.ARID_S;
                        r_addr    <= w_ar_word;
                        r_len     <= axi.ARLEN_S;
                        r_burst   <= axi.ARBURST_S;
                        r_beat    <= '0;
                        if (w_slverr || w_decerr) begin
                            // Protocol errors take priority over address decode.
                            r_state  <= c_ERR;
                            r_rvalid <= 1'b1;
                            r_rdata  <= '0;
                            r_rresp  <= w_slverr ? 2'd2 : 2'd3;
                            r_rlast  <= (axi.ARLEN_S == '0);
                        end else begin
                            r_state    <= c_ACCESS;
                            r_rresp    <= 2'd0;
                            r_rom_en   <= 1'b1;
                            r_rom_addr <= w_ar_word;
                            r_lat      <= c_LAT_W'(ROM_LAT);
                        end
                    end
                end
                c_ACCESS: begin
                    if (r_lat == c_LAT_W'(1)) begin
                        r_state  <= c_DATA;
                        r_rdata  <= ROM_out;
                        r_rom_en <= 1'b0;
                        r_rvalid <= 1'b1;
                        r_rlast  <= (r_beat == r_len);
                    end else begin
                        r_lat <= r_lat - c_LAT_W'(1);
                    end
                end
                c_DATA: begin
                    if (axi.RREADY_S) begin
                        r_rvalid <= 1'b0;
                        if (r_beat == r_len) begin
                            r_state   <= c_IDLE;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                        end else begin
                            r_state    <= c_ACCESS;
                            r_beat     <= r_beat + c_LEN_W'(1);
                            r_addr     <= w_next_addr;
                            r_rom_addr <= w_next_addr;
                            r_rom_en   <= 1'b1;
                            r_lat      <= c_LAT_W'(ROM_LAT);
                        end
                    end
                end
                c_ERR: begin
                    if (axi.RREADY_S) begin
                        if (r_beat == r_len) begin
                            r_state   <= c_IDLE;
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                        end else begin
                            r_beat  <= r_beat + c_LEN_W'(1);
                            r_rlast <= ((r_beat + c_LEN_W'(1)) == r_len);
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign axi.ARREADY_S = r_arready;
    assign axi.RID_S     = r_rid;
    assign axi.RDATA_S   = r_rdata;
    assign axi.RRESP_S   = r_rresp;
    assign axi.RLAST_S   = r_rlast;
    assign axi.RVALID_S  = r_rvalid;
    assign ROM_enable    = r_rom_en;
    assign ROM_read      = r_rom_en;
    assign ROM_address   = r_rom_addr;

endmodule

`default_nettype wire

// File: tb/tb_rom_axi_rd_slave.sv
//------------------------------------------------------------------------------
// Module     : tb_rom_axi_rd_slave
// Description: Directed self-checking bench for rom_axi_rd_slave with
//              ADDR_W=12 and ROM_LAT=3. Expectations for WRAP bursts follow
//              the ROM_WRAP_EN macro.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 4
`endif

module tb_rom_axi_rd_slave;

    localparam int c_ADDR_W = 12;
    localparam int c_LAT    = 3;
    localparam int c_ID_W   = `AXI_IDS_BITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rom_axi_rd_slave_if #(.ID_W(c_ID_W)) axi ();

    logic                rom_enable;
    logic                rom_read;
    logic [c_ADDR_W-1:0] rom_address;
    logic [31:0]         rom_out;

    rom_axi_rd_slave #(
        .ADDR_W (c_ADDR_W),
        .ROM_LAT(c_LAT),
        .ID_W   (c_ID_W)
    ) u_dut (
        .ACLK       (clk),
        .ARESETn    (rst_n),
        .axi        (axi),
        .ROM_enable (rom_enable),
        .ROM_read   (rom_read),
        .ROM_address(rom_address),
        .ROM_out    (rom_out)
    );

    function automatic logic [31:0] rom_word(input logic [c_ADDR_W-1:0] a);
        return {8'hA5, 4'h0, a, 8'h3C};
    endfunction

    // ROM model: data only becomes valid in the c_LAT-th enabled cycle.
    int                  cyc = 0;
    int                  en_cnt = 0;
    int                  en_total = 0;
    int                  addr_unstable = 0;
    logic [c_ADDR_W-1:0] prev_addr = '0;
    logic [c_ADDR_W-1:0] addr_log[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rom_enable) begin
            if (en_cnt == 0) addr_log.push_back(rom_address);
            else if (rom_address != prev_addr) addr_unstable++;
            prev_addr = rom_address;
            en_cnt++;
            en_total++;
        end else begin
            en_cnt = 0;
        end
    end

    assign rom_out = (rom_enable && en_cnt == c_LAT) ? rom_word(rom_address) : 32'hDEAD_BEEF;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int t_ar;
    task automatic ar_send(input logic [c_ID_W-1:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clk);
        axi.ARID_S    = id;
        axi.ARADDR_S  = addr;
        axi.ARLEN_S   = len;
        axi.ARSIZE_S  = size;
        axi.ARBURST_S = burst;
        axi.ARVALID_S = 1'b1;
        while (axi.ARREADY_S !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ar_timeout", 32'd1, 32'd0);
        t_ar = cyc;
        @(negedge clk);
        axi.ARVALID_S = 1'b0;
    endtask

    logic [31:0]       b_data[16];
    logic [1:0]        b_resp[16];
    logic              b_last[16];
    logic [c_ID_W-1:0] b_id[16];
    int                b_cyc[16];
    int                stall_beat = -1;
    int                stall_len  = 0;

    // Starts at a negedge; each accepted beat is recorded in its handshake cycle.
    task automatic collect(input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            int          n = 0;
            logic [31:0] s_data;
            logic        s_last;
            axi.RREADY_S = (b != stall_beat);
            while (axi.RVALID_S !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) begin
                check("r_timeout", 32'd1, 32'd0);
                axi.RREADY_S = 1'b1;
                return;
            end
            if (b == stall_beat) begin
                s_data = axi.RDATA_S;
                s_last = axi.RLAST_S;
                repeat (stall_len) begin
                    @(negedge clk);
                    check("stall_rvalid",  32'(axi.RVALID_S),  32'd1);
                    check("stall_rdata",   axi.RDATA_S,        s_data);
                    check("stall_rlast",   32'(axi.RLAST_S),   32'(s_last));
                    check("stall_rom_en",  32'(rom_enable),    32'd0);
                    check("stall_arready", 32'(axi.ARREADY_S), 32'd0);
                end
                axi.RREADY_S = 1'b1;
            end
            b_data[b] = axi.RDATA_S;
            b_resp[b] = axi.RRESP_S;
            b_last[b] = axi.RLAST_S;
            b_id[b]   = axi.RID_S;
            b_cyc[b]  = cyc;
            @(negedge clk);
        end
        stall_beat = -1;
    endtask

    task automatic clear_mon();
        addr_log.delete();
        en_total      = 0;
        addr_unstable = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_arready"}, 32'(axi.ARREADY_S), 32'd0);
        check({tag, "_rvalid"},  32'(axi.RVALID_S),  32'd0);
        check({tag, "_rlast"},   32'(axi.RLAST_S),   32'd0);
        check({tag, "_rdata"},   axi.RDATA_S,        32'd0);
        check({tag, "_rid"},     32'(axi.RID_S),     32'd0);
        check({tag, "_rresp"},   32'(axi.RRESP_S),   32'd0);
        check({tag, "_rom_en"},  32'(rom_enable),    32'd0);
        check({tag, "_rom_rd"},  32'(rom_read),      32'd0);
        check({tag, "_rom_adr"}, 32'(rom_address),   32'd0);
    endtask

    initial begin
        logic [c_ADDR_W-1:0] exp_a[4];
        int                  rv;
        int                  n;

        axi.ARID_S    = '0;
        axi.ARADDR_S  = '0;
        axi.ARLEN_S   = '0;
        axi.ARSIZE_S  = '0;
        axi.ARBURST_S = '0;
        axi.ARVALID_S = 1'b0;
        axi.RREADY_S  = 1'b1;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("arready_after_reset", 32'(axi.ARREADY_S), 32'd1);

        // Single beat: word 4, OKAY
        clear_mon();
        ar_send(4'h5, 32'h10, 4'd0, 3'd2, 2'd1);
        collect(1);
        check("single_nrom",   32'(addr_log.size()), 32'd1);
        if (addr_log.size() > 0) check("single_addr", 32'(addr_log[0]), 32'd4);
        check("single_en_cyc", 32'(en_total),        32'(c_LAT));
        check("single_lat",    32'(b_cyc[0] - t_ar), 32'(1 + c_LAT));
        check("single_data",   b_data[0],            rom_word(12'd4));
        check("single_last",   32'(b_last[0]),       32'd1);
        check("single_resp",   32'(b_resp[0]),       32'd0);
        check("single_id",     32'(b_id[0]),         32'h5);
        check("single_arready_back", 32'(axi.ARREADY_S), 32'd1);

        // INCR across the top of the ROM
        clear_mon();
        exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        ar_send(4'h1, 32'h3FF8, 4'd3, 3'd2, 2'd1);
        collect(4);
        check("incr_nrom", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size()) check("incr_addr", 32'(addr_log[i]), 32'(exp_a[i]));
            check("incr_data", b_data[i],       rom_word(exp_a[i]));
            check("incr_last", 32'(b_last[i]),  32'(i == 3));
            check("incr_resp", 32'(b_resp[i]),  32'd0);
            if (i > 0) check("incr_gap", 32'(b_cyc[i] - b_cyc[i-1]), 32'(c_LAT + 1));
        end

        // Back-pressure on beat 2 of a 4-beat INCR
        clear_mon();
        stall_beat = 1;
        stall_len  = 5;
        ar_send(4'h2, 32'h100, 4'd3, 3'd2, 2'd1);
        collect(4);
        check("bp_nrom",     32'(addr_log.size()), 32'd4);
        check("bp_unstable", 32'(addr_unstable),   32'd0);
        check("bp_en_cyc",   32'(en_total),        32'(4 * c_LAT));
        for (int i = 0; i < 4; i++) begin
            check("bp_data", b_data[i],      rom_word(12'h040 + 12'(i)));
            check("bp_last", 32'(b_last[i]), 32'(i == 3));
        end
        check("bp_gap", 32'(b_cyc[3] - b_cyc[2]), 32'(c_LAT + 1));

        // WRAP, LEN=3 starting at word 6
        clear_mon();
        ar_send(4'h3, 32'h18, 4'd3, 3'd2, 2'd2);
        collect(4);
`ifdef ROM_WRAP_EN
        exp_a = '{12'h006, 12'h007, 12'h004, 12'h005};
        check("wrap_nrom", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size()) check("wrap_addr", 32'(addr_log[i]), 32'(exp_a[i]));
            check("wrap_data", b_data[i],      rom_word(exp_a[i]));
            check("wrap_resp", 32'(b_resp[i]), 32'd0);
            check("wrap_last", 32'(b_last[i]), 32'(i == 3));
        end
`else
        check("wrap_en_cyc", 32'(en_total),        32'd0);
        check("wrap_first",  32'(b_cyc[0] - t_ar), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("wrap_resp", 32'(b_resp[i]), 32'd2);
            check("wrap_data", b_data[i],      32'd0);
            check("wrap_last", 32'(b_last[i]), 32'(i == 3));
            if (i > 0) check("wrap_gap", 32'(b_cyc[i] - b_cyc[i-1]), 32'd1);
        end
`endif

        // Illegal size: 2 SLVERR beats from T+1, back to back
        clear_mon();
        ar_send(4'h4, 32'h0, 4'd1, 3'd1, 2'd1);
        collect(2);
        check("size_first",  32'(b_cyc[0] - t_ar),     32'd1);
        check("size_gap",    32'(b_cyc[1] - b_cyc[0]), 32'd1);
        check("size_resp0",  32'(b_resp[0]),           32'd2);
        check("size_resp1",  32'(b_resp[1]),           32'd2);
        check("size_last0",  32'(b_last[0]),           32'd0);
        check("size_last1",  32'(b_last[1]),           32'd1);
        check("size_data",   b_data[1],                32'd0);
        check("size_id",     32'(b_id[0]),             32'h4);
        check("size_en_cyc", 32'(en_total),            32'd0);
        check("size_arready_back", 32'(axi.ARREADY_S), 32'd1);

        // Out-of-range address: DECERR
        clear_mon();
        ar_send(4'h6, 32'h4000, 4'd0, 3'd2, 2'd1);
        collect(1);
        check("dec_resp",   32'(b_resp[0]), 32'd3);
        check("dec_last",   32'(b_last[0]), 32'd1);
        check("dec_data",   b_data[0],      32'd0);
        check("dec_en_cyc", 32'(en_total),  32'd0);

        // Reserved burst type: SLVERR
        clear_mon();
        ar_send(4'h9, 32'h20, 4'd0, 3'd2, 2'd3);
        collect(1);
        check("burst3_resp",   32'(b_resp[0]), 32'd2);
        check("burst3_en_cyc", 32'(en_total),  32'd0);

        // Reset during beat 3 of an 8-beat INCR
        clear_mon();
        ar_send(4'h7, 32'h200, 4'd7, 3'd2, 2'd1);
        collect(2);
        check("mid_beat1_data", b_data[1], rom_word(12'h081));
        n = 0;
        while (axi.RVALID_S !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_beat3_seen", 32'(axi.RVALID_S), 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        rv = 0;
        repeat (10) begin
            @(negedge clk);
            if (axi.RVALID_S === 1'b1) rv++;
        end
        check("midrst_no_residual", 32'(rv), 32'd0);
        ar_send(4'h8, 32'h20, 4'd0, 3'd2, 2'd1);
        collect(1);
        check("post_rst_data", b_data[0],      rom_word(12'h008));
        check("post_rst_resp", 32'(b_resp[0]), 32'd0);
        check("post_rst_last", 32'(b_last[0]), 32'd1);
        check("post_rst_id",   32'(b_id[0]),   32'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
